// File: rtl/axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// axi_lite_pkg
// Items shared by the AXI-Lite read arbiter files:
//   - state_e : arbiter FSM states (IDLE, ADDR, DATA)
//   - OKAY / SLVERR : AXI read response encodings
//   - DEF_ADDR_W / DEF_DATA_W : default address and data widths
// ---------------------------------------------------------------------------
package axi_lite_pkg;

    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

endpackage

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-way round-robin pick, purely combinational.
//   req    in  2  request bits, req[i] = master i is asking
//   prio   in  1  master that wins when both ask
//   winner out 1  index of the selected master
//   valid  out 1  at least one request is present
// With a single requester that requester wins regardless of prio.
// ---------------------------------------------------------------------------
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       prio,
    output logic       winner,
    output logic       valid
);

    // NOTE: every output is assigned on every path through this block, so no
    // latch can be inferred.
    always_comb begin
        valid = |req;
        if (&req) begin
            winner = prio;
        end else begin
            winner = req[1];
        end
    end

endmodule

// File: rtl/axi_lite_read_arbiter.sv
// ---------------------------------------------------------------------------
// axi_lite_read_arbiter
// Shares one AXI-Lite slave read port between two masters, one transaction
// outstanding at a time, round-robin when both request together.
//   ACLK, ARESETn           clock; synchronous active-high reset (1 = reset)
//   M0_*/M1_* AR channel    ARVALID/ARADDR in, ARREADY out
//   M0_*/M1_* R channel     RVALID/RDATA/RRESP out, RREADY in
//   S_* AR channel          ARVALID/ARADDR out, ARREADY in
//   S_* R channel           RVALID/RDATA/RRESP in, RREADY out
//   GRANT                   master owning the current transaction
//   BUSY                    a transaction is in flight
// Address acceptance and R routing are combinational; all state is held in
// one clocked process. While reset is asserted every handshake output is
// forced low so nothing is accepted or completed during that cycle.
// ---------------------------------------------------------------------------
module axi_lite_read_arbiter
    import axi_lite_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              ACLK,
    input  logic              ARESETn,

    input  logic              M0_ARVALID,
    input  logic [ADDR_W-1:0] M0_ARADDR,
    output logic              M0_ARREADY,
    output logic              M0_RVALID,
    input  logic              M0_RREADY,
    output logic [DATA_W-1:0] M0_RDATA,
    output logic [1:0]        M0_RRESP,

    input  logic              M1_ARVALID,
    input  logic [ADDR_W-1:0] M1_ARADDR,
    output logic              M1_ARREADY,
    output logic              M1_RVALID,
    input  logic              M1_RREADY,
    output logic [DATA_W-1:0] M1_RDATA,
    output logic [1:0]        M1_RRESP,

    output logic              S_ARVALID,
    output logic [ADDR_W-1:0] S_ARADDR,
    input  logic              S_ARREADY,
    input  logic              S_RVALID,
    input  logic [DATA_W-1:0] S_RDATA,
    input  logic [1:0]        S_RRESP,
    output logic              S_RREADY,

    output logic              GRANT,
    output logic              BUSY
);

    state_e            state;
    logic              prio;
    logic              grant_q;
    logic [ADDR_W-1:0] addr_q;
    logic              busy_q;

    logic              winner;
    logic              win_valid;

    rr_arbiter2 u_rr (
        .req    ({M1_ARVALID, M0_ARVALID}),
        .prio   (prio),
        .winner (winner),
        .valid  (win_valid)
    );

    // Reset suppresses every handshake in the cycle it is asserted.
    logic active;
    logic in_idle;
    logic in_addr;
    logic in_data;
    logic sel0;
    logic sel1;

    assign active  = ~ARESETn;
    assign in_idle = active && (state == IDLE);
    assign in_addr = active && (state == ADDR);
    assign in_data = active && (state == DATA);
    assign sel0    = in_data && !grant_q;
    assign sel1    = in_data &&  grant_q;

    // AR acceptance: only in IDLE, only for the arbitration winner.
    assign M0_ARREADY = in_idle && win_valid && !winner;
    assign M1_ARREADY = in_idle && win_valid &&  winner;

    // Shared slave AR channel driven from the latched address.
    assign S_ARVALID = in_addr;
    assign S_ARADDR  = in_addr ? addr_q : '0;

    // R routing: the non-granted master always sees zeros.
    assign M0_RVALID = sel0 && S_RVALID;
    assign M0_RDATA  = sel0 ? S_RDATA : '0;
    assign M0_RRESP  = sel0 ? S_RRESP : OKAY;
    assign M1_RVALID = sel1 && S_RVALID;
    assign M1_RDATA  = sel1 ? S_RDATA : '0;
    assign M1_RRESP  = sel1 ? S_RRESP : OKAY;
    assign S_RREADY  = in_data && (grant_q ? M1_RREADY : M0_RREADY);

    assign GRANT = grant_q;
    assign BUSY  = busy_q && active;

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge ACLK) begin
        if (ARESETn) begin
            state   <= IDLE;
            prio    <= 1'b0;
            grant_q <= 1'b0;
            addr_q  <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (win_valid) begin
                        addr_q  <= winner ? M1_ARADDR : M0_ARADDR;
                        grant_q <= winner;
                        busy_q  <= 1'b1;
                        state   <= ADDR;
                    end
                end
                ADDR: begin
                    // S_ARVALID is high throughout ADDR, so ARREADY alone
                    // completes the handshake.
                    if (S_ARREADY) begin
                        state <= DATA;
                    end
                end
                DATA: begin
                    if (S_RVALID && S_RREADY) begin
                        // Hand priority to the master that just waited.
                        prio   <= !grant_q;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_read_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi_lite_read_arbiter
// Directed bench for axi_lite_read_arbiter. A transaction-level model
// (owner / address-phase / priority) predicts every output on each falling
// edge; a monitor records completed reads and accepted addresses so the
// directed scenarios can pin literal expectations on them.
// ---------------------------------------------------------------------------
module tb_axi_lite_read_arbiter;
    import axi_lite_pkg::*;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          ACLK = 1'b0;
    logic          ARESETn;
    logic          M0_ARVALID, M1_ARVALID;
    logic [AW-1:0] M0_ARADDR,  M1_ARADDR;
    logic          M0_ARREADY, M1_ARREADY;
    logic          M0_RVALID,  M1_RVALID;
    logic          M0_RREADY,  M1_RREADY;
    logic [DW-1:0] M0_RDATA,   M1_RDATA;
    logic [1:0]    M0_RRESP,   M1_RRESP;
    logic          S_ARVALID;
    logic [AW-1:0] S_ARADDR;
    logic          S_ARREADY;
    logic          S_RVALID;
    logic [DW-1:0] S_RDATA;
    logic [1:0]    S_RRESP;
    logic          S_RREADY;
    logic          GRANT, BUSY;

    axi_lite_read_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn),
        .M0_ARVALID(M0_ARVALID), .M0_ARADDR(M0_ARADDR), .M0_ARREADY(M0_ARREADY),
        .M0_RVALID(M0_RVALID), .M0_RREADY(M0_RREADY), .M0_RDATA(M0_RDATA), .M0_RRESP(M0_RRESP),
        .M1_ARVALID(M1_ARVALID), .M1_ARADDR(M1_ARADDR), .M1_ARREADY(M1_ARREADY),
        .M1_RVALID(M1_RVALID), .M1_RREADY(M1_RREADY), .M1_RDATA(M1_RDATA), .M1_RRESP(M1_RRESP),
        .S_ARVALID(S_ARVALID), .S_ARADDR(S_ARADDR), .S_ARREADY(S_ARREADY),
        .S_RVALID(S_RVALID), .S_RDATA(S_RDATA), .S_RRESP(S_RRESP), .S_RREADY(S_RREADY),
        .GRANT(GRANT), .BUSY(BUSY)
    );

    always #5 ACLK = ~ACLK;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level reference model ----------------
    bit            model_live = 0;
    bit            m_busy, m_addr_phase, m_prio, m_grant;
    logic [AW-1:0] m_addr;

    function automatic logic pick(input logic r0, input logic r1, input logic p);
        return (r0 && r1) ? p : r1;
    endfunction

    always @(posedge ACLK) begin
        if (ARESETn) begin
            m_busy <= 0; m_addr_phase <= 0; m_prio <= 0; m_grant <= 0; m_addr <= '0;
            model_live <= 1;
        end else if (model_live) begin
            if (!m_busy) begin
                if (M0_ARVALID || M1_ARVALID) begin
                    m_busy       <= 1;
                    m_addr_phase <= 1;
                    m_grant      <= pick(M0_ARVALID, M1_ARVALID, m_prio);
                    m_addr       <= pick(M0_ARVALID, M1_ARVALID, m_prio) ? M1_ARADDR : M0_ARADDR;
                end
            end else if (m_addr_phase) begin
                if (S_ARREADY) m_addr_phase <= 0;
            end else if (S_RVALID && (m_grant ? M1_RREADY : M0_RREADY)) begin
                m_busy <= 0;
                m_prio <= !m_grant;
            end
        end
    end

    logic          e_arr[2], e_rv[2];
    logic [DW-1:0] e_rd[2];
    logic [1:0]    e_rr[2];
    logic          e_sarv, e_srr, e_busy;
    logic [AW-1:0] e_sara;

    always @(negedge ACLK) begin
        if (model_live) begin
            e_arr[0] = 0; e_arr[1] = 0; e_rv[0] = 0; e_rv[1] = 0;
            e_rd[0] = '0; e_rd[1] = '0; e_rr[0] = OKAY; e_rr[1] = OKAY;
            e_sarv = 0; e_sara = '0; e_srr = 0; e_busy = 0;
            if (!ARESETn) begin
                if (!m_busy) begin
                    if (M0_ARVALID || M1_ARVALID)
                        e_arr[pick(M0_ARVALID, M1_ARVALID, m_prio)] = 1;
                end else if (m_addr_phase) begin
                    e_busy = 1; e_sarv = 1; e_sara = m_addr;
                end else begin
                    e_busy = 1;
                    e_rv[m_grant] = S_RVALID;
                    e_rd[m_grant] = S_RDATA;
                    e_rr[m_grant] = S_RRESP;
                    e_srr = m_grant ? M1_RREADY : M0_RREADY;
                end
            end
            check("M0_ARREADY", M0_ARREADY, e_arr[0]);
            check("M1_ARREADY", M1_ARREADY, e_arr[1]);
            check("M0_RVALID",  M0_RVALID,  e_rv[0]);
            check("M1_RVALID",  M1_RVALID,  e_rv[1]);
            check("M0_RDATA",   M0_RDATA,   e_rd[0]);
            check("M1_RDATA",   M1_RDATA,   e_rd[1]);
            check("M0_RRESP",   M0_RRESP,   e_rr[0]);
            check("M1_RRESP",   M1_RRESP,   e_rr[1]);
            check("S_ARVALID",  S_ARVALID,  e_sarv);
            check("S_ARADDR",   S_ARADDR,   e_sara);
            check("S_RREADY",   S_RREADY,   e_srr);
            check("BUSY",       BUSY,       e_busy);
            check("GRANT",      GRANT,      m_grant);
        end
    end

    // ---------------- monitor of DUT-visible events ----------------
    logic [31:0] done_idx[$];
    logic [31:0] done_data[$];
    logic [31:0] done_grant[$];
    logic [31:0] ar_addrs[$];

    always @(negedge ACLK) begin
        if (!ARESETn) begin
            if (M0_RVALID && M0_RREADY) begin
                done_idx.push_back(0); done_data.push_back(M0_RDATA); done_grant.push_back({31'd0, GRANT});
            end
            if (M1_RVALID && M1_RREADY) begin
                done_idx.push_back(1); done_data.push_back(M1_RDATA); done_grant.push_back({31'd0, GRANT});
            end
            if (S_ARVALID && S_ARREADY) ar_addrs.push_back(S_ARADDR);
        end
    end

    function automatic logic [31:0] qa(input logic [31:0] q[$], input int i);
        if (i < q.size()) return q[i];
        return 'x;
    endfunction

    // ---------------- master and slave stimulus ----------------
    int            req_left[2];
    logic [AW-1:0] next_addr[2];
    int            rr_stall[2];
    int            ar_wait, ar_cnt;
    bit            r_pending, use_override;
    logic [DW-1:0] r_data, override_data;

    task automatic drive_outputs();
        M0_ARVALID = (req_left[0] != 0); M0_ARADDR = next_addr[0];
        M1_ARVALID = (req_left[1] != 0); M1_ARADDR = next_addr[1];
        M0_RREADY  = (rr_stall[0] == 0);
        M1_RREADY  = (rr_stall[1] == 0);
        S_ARREADY  = (ar_cnt >= ar_wait);
        S_RVALID   = r_pending;
        S_RDATA    = r_pending ? r_data : '0;
        S_RRESP    = (r_pending && r_data[4]) ? SLVERR : OKAY;
    endtask

    task automatic set_master(input int i, input int n, input logic [AW-1:0] a);
        req_left[i] = n; next_addr[i] = a;
        drive_outputs();
    endtask

    // One clock: observe handshakes mid-cycle, update stimulus just after the edge.
    task automatic step();
        bit hs_m[2], rv[2];
        bit hs_ar, hs_r, sarv;
        logic [AW-1:0] sara;
        @(negedge ACLK);
        hs_m[0] = M0_ARVALID && M0_ARREADY; hs_m[1] = M1_ARVALID && M1_ARREADY;
        rv[0] = M0_RVALID; rv[1] = M1_RVALID;
        hs_ar = S_ARVALID && S_ARREADY; hs_r = S_RVALID && S_RREADY;
        sarv = S_ARVALID; sara = S_ARADDR;
        @(posedge ACLK); #1;
        for (int i = 0; i < 2; i++) begin
            if (hs_m[i]) begin req_left[i]--; next_addr[i] += 4; end
            if (rv[i] && rr_stall[i] > 0) rr_stall[i]--;
        end
        if (hs_ar) begin
            r_pending = 1; ar_cnt = 0;
            r_data = use_override ? override_data : (sara ^ 32'h5A5A_0000);
        end else if (sarv) begin
            ar_cnt++;
        end
        if (hs_r) r_pending = 0;
        drive_outputs();
    endtask

    task automatic clear_stim();
        req_left[0] = 0; req_left[1] = 0; next_addr[0] = '0; next_addr[1] = '0;
        rr_stall[0] = 0; rr_stall[1] = 0; ar_wait = 0; ar_cnt = 0;
        r_pending = 0; r_data = '0; use_override = 0; override_data = '0;
        drive_outputs();
    endtask

    task automatic do_reset();
        ARESETn = 1'b1;
        clear_stim();
        step(); step();
        ARESETn = 1'b0;
        done_idx.delete(); done_data.delete(); done_grant.delete(); ar_addrs.delete();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        ARESETn = 1'b1;
        clear_stim();

        // ---- M0 alone, zero-wait slave ----
        do_reset();
        use_override = 1; override_data = 32'hDEAD_BEEF;
        set_master(0, 1, 32'h10);
        #1 check("t1_c0_m0_arready", M0_ARREADY, 1);
        check("t1_c0_m1_arready", M1_ARREADY, 0);
        step(); #1;
        check("t1_c1_s_arvalid", S_ARVALID, 1);
        check("t1_c1_s_araddr", S_ARADDR, 32'h10);
        step(); #1;
        check("t1_c2_m0_rvalid", M0_RVALID, 1);
        check("t1_c2_m0_rdata", M0_RDATA, 32'hDEAD_BEEF);
        check("t1_c2_m0_rresp", M0_RRESP, 2'b00);
        check("t1_c2_m1_rvalid", M1_RVALID, 0);
        check("t1_c2_m1_rdata", M1_RDATA, 0);
        check("t1_c2_m1_rresp", M1_RRESP, 0);
        step(); #1;
        check("t1_c3_busy", BUSY, 0);

        // ---- simultaneous request from reset ----
        do_reset();
        set_master(0, 1, 32'h100);
        set_master(1, 1, 32'h200);
        #1 check("t2_c0_m0_arready", M0_ARREADY, 1);
        check("t2_c0_m1_arready", M1_ARREADY, 0);
        repeat (3) step();
        #1 check("t2_c3_m1_arready", M1_ARREADY, 1);
        repeat (4) step();
        check("t2_ndone", done_idx.size(), 2);
        check("t2_grant0", qa(done_grant, 0), 0);
        check("t2_grant1", qa(done_grant, 1), 1);
        check("t2_addr0", qa(ar_addrs, 0), 32'h100);
        check("t2_addr1", qa(ar_addrs, 1), 32'h200);
        check("t2_data1", qa(done_data, 1), 32'h5A5A_0200);

        // ---- continuous contention: four alternating grants ----
        do_reset();
        set_master(0, 2, 32'h1000);
        set_master(1, 2, 32'h2000);
        repeat (14) step();
        check("t3_ndone", done_idx.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("t3_grant%0d", i), qa(done_grant, i), i % 2);
        check("t3_addr2", qa(ar_addrs, 2), 32'h1004);

        // ---- slow slave AR and stalled M1 RREADY ----
        do_reset();
        ar_wait = 3; rr_stall[1] = 2;
        set_master(1, 1, 32'h3D0);
        repeat (7) step();
        #1 check("t4_c7_busy", BUSY, 1);
        check("t4_c7_m1_rvalid", M1_RVALID, 1);
        check("t4_c7_m1_rready", M1_RREADY, 1);
        check("t4_c7_m1_rdata", M1_RDATA, 32'h5A5A_03D0);
        check("t4_c7_m1_rresp", M1_RRESP, SLVERR);
        step(); #1;
        check("t4_c8_busy", BUSY, 0);
        check("t4_ndone", done_idx.size(), 1);
        check("t4_addr", qa(ar_addrs, 0), 32'h3D0);

        // ---- reset while in DATA with S_RVALID high ----
        do_reset();
        rr_stall[1] = 10;
        set_master(1, 1, 32'h700);
        step(); step();
        ARESETn = 1'b1;
        #1 check("t5_rst_s_rvalid_in", S_RVALID, 1);
        check("t5_rst_busy", BUSY, 0);
        check("t5_rst_m1_rvalid", M1_RVALID, 0);
        check("t5_rst_s_rready", S_RREADY, 0);
        check("t5_rst_s_arvalid", S_ARVALID, 0);
        step();
        ARESETn = 1'b0;
        r_pending = 0; rr_stall[1] = 0;
        drive_outputs();
        #1 check("t5_after_busy", BUSY, 0);
        check("t5_after_m0_rvalid", M0_RVALID, 0);
        check("t5_after_m1_rvalid", M1_RVALID, 0);
        check("t5_after_grant", GRANT, 0);
        set_master(0, 1, 32'h500);
        set_master(1, 1, 32'h600);
        #1 check("t5_prio_m0_arready", M0_ARREADY, 1);
        check("t5_prio_m1_arready", M1_ARREADY, 0);
        repeat (7) step();
        check("t5_ndone", done_idx.size(), 2);
        check("t5_first_idx", qa(done_idx, 0), 0);

        // ---- M1 arrives while M0 is in ADDR ----
        do_reset();
        ar_wait = 1;
        set_master(0, 1, 32'h20);
        #1 check("t6_c0_m0_arready", M0_ARREADY, 1);
        step();
        set_master(1, 1, 32'h440);
        #1 check("t6_c1_m1_arready", M1_ARREADY, 0);
        check("t6_c1_busy", BUSY, 1);
        step(); #1;
        check("t6_c2_m1_arready", M1_ARREADY, 0);
        step(); #1;
        check("t6_c3_m1_arready", M1_ARREADY, 0);
        step(); #1;
        check("t6_c4_m1_arready", M1_ARREADY, 1);
        step(); #1;
        check("t6_c5_grant", GRANT, 1);
        check("t6_c5_s_araddr", S_ARADDR, 32'h440);
        repeat (4) step();
        check("t6_ndone", done_idx.size(), 2);
        check("t6_second_idx", qa(done_idx, 1), 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/axi_lite_read_arbiter.md
AXI_LITE_READ_ARBITER -- requirements
Module: axi_lite_read_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, address width of all AR channels.
REQ-002 Parameter DATA_W, default 32, data width of all R channels.
REQ-003 The block SHALL use one clock and a reset that is synchronous and active-high.
REQ-004 ACLK  in  1  sole clock, all state updates on its rising edge.
REQ-005 ARESETn  in  1  reset, synchronous and active-high (1 = reset).
REQ-006 M0_ARVALID/M1_ARVALID  in  1  master read-address request.
REQ-007 M0_ARADDR/M1_ARADDR  in  ADDR_W  master read address.
REQ-008 M0_ARREADY/M1_ARREADY  out  1  address accepted from that master.
REQ-009 M0_RVALID/M1_RVALID  out  1  read data valid to that master.
REQ-010 M0_RREADY/M1_RREADY  in  1  master accepts read data.
REQ-011 M0_RDATA/M1_RDATA  out  DATA_W; M0_RRESP/M1_RRESP  out  2  routed read data and response.
REQ-012 S_ARVALID  out  1; S_ARADDR  out  ADDR_W; S_ARREADY  in  1  shared slave AR channel.
REQ-013 S_RVALID  in  1; S_RDATA  in  DATA_W; S_RRESP  in  2; S_RREADY  out  1  shared slave R channel.
REQ-014 GRANT  out  1  index of the master that owns the current transaction (0 or 1).
REQ-015 BUSY  out  1  high whenever state is not IDLE.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, ADDR, DATA; one read transaction is outstanding at most.
REQ-017 IDLE: if either Mx_ARVALID is high, the arbiter SHALL select a winner combinationally. A sole requester wins. If both request, the master named by the round-robin pointer PRIO wins.
REQ-018 IDLE: the winner's MX_ARREADY SHALL be high in the same cycle (combinational). The loser's ARREADY SHALL be 0.
REQ-019 On that IDLE edge, the winner's ARADDR SHALL be latched into addr_q and its index into GRANT, and state SHALL go to ADDR.
REQ-020 ADDR: S_ARVALID = 1 and S_ARADDR = addr_q, held stable until S_ARREADY. On S_ARVALID && S_ARREADY, state SHALL go to DATA.
REQ-021 DATA: S_RVALID, S_RDATA and S_RRESP SHALL be routed combinationally to the granted master, and S_RREADY SHALL equal that master's RREADY.
REQ-022 DATA: the non-granted master SHALL see RVALID = 0, RDATA = 0 and RRESP = 0 at all times.
REQ-023 DATA: on S_RVALID && S_RREADY, state SHALL return to IDLE, and PRIO SHALL be set to the non-granted master's index.
REQ-024 Outside DATA: S_RREADY = 0, and both MX_RVALID = 0.
REQ-025 Outside ADDR: S_ARVALID = 0 and S_ARADDR = 0.
REQ-026 Outside IDLE: both MX_ARREADY SHALL be 0. Requests arriving while BUSY SHALL wait and are not dropped.
REQ-027 Minimum latency: IDLE -> ADDR -> DATA -> IDLE is 3 cycles with zero-wait slave; back-to-back grants SHALL be possible on consecutive IDLE cycles.
REQ-028 PRIO SHALL change only on completed R handshakes, never on a single-requester grant without completion.
REQ-029 If RVALID is stalled by the master (RREADY = 0), the arbiter SHALL stay in DATA indefinitely, with data passed through unchanged.

Reset
REQ-030 When ARESETn = 1 at a rising edge, state = IDLE, PRIO = 0, GRANT = 0, addr_q = 0, regardless of current state.
REQ-031 If reset occurs mid-ADDR or mid-DATA, the transaction SHALL be abandoned with no completion signalled to any master.
REQ-032 During reset and the cycle after: S_ARVALID = 0, S_RREADY = 0, BUSY = 0, all MX_RVALID = 0.

Structure
REQ-033 Shared package axi_lite_pkg: state enum {IDLE, ADDR, DATA}, RESP constants OKAY = 2'b00 and SLVERR = 2'b10, and the default widths.
REQ-034 One sub-module is natural: rr_arbiter2. It takes two request bits and PRIO, and returns a winner index and a valid flag, purely combinationally.
REQ-035 All registers SHALL be in a single clocked process. Routing muxes SHALL be combinational.

Verification
REQ-036 M0 only, ARADDR = 0x10, slave ARREADY = 1, RDATA = 0xDEADBEEF, RRESP = 0. Required: M0_ARREADY in cycle 0, S_ARVALID in cycle 1, M0_RDATA = 0xDEADBEEF in cycle 2, M1 outputs all 0.
REQ-037 M0 and M1 request simultaneously from reset (M0 = 0x100, M1 = 0x200). Required: M0 is served first, then M1 with S_ARADDR = 0x200, GRANT sequence 0 then 1.
REQ-038 Both request continuously for 4 transactions. Required: GRANT alternates 0, 1, 0, 1.
REQ-039 Slave ARREADY delayed 3 cycles and M1 RREADY low for 2 cycles. Required: S_ARADDR stable throughout, data to M1 unchanged until the handshake, then BUSY drops.
REQ-040 Reset asserted while in DATA with S_RVALID = 1. Required: next cycle BUSY = 0, M0_RVALID = M1_RVALID = 0, PRIO = 0.
REQ-041 M1 raises ARVALID while M0's transaction is in ADDR. Required: M1_ARREADY stays 0 until IDLE, then M1 is granted on the first IDLE cycle.
